// File: rtl/dev_arb_pkg.sv
// Shared types and widths for the device arbiter slice.
package dev_arb_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAKE = 2'd1,
    ST_XFER = 2'd2
  } state_t;

endpackage

// File: rtl/dev_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = ptr_i;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/dev_arbiter.sv
// Arbitrates NUM_REQ requesters onto one device port, waking the device first
// when it reports sleep mode.
module dev_arbiter
  import dev_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WAKE_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic                             dev_valid_o,
  output logic [ADDR_W-1:0]                dev_addr_o,
  output logic [DATA_W-1:0]                dev_data_o,
  input  logic                             dev_ready_i,
  input  logic                             dev_opmode_i,
  output logic                             dev_wake_o,
  output logic                             wake_err_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WAKE_TIMEOUT > 1) ? $clog2(WAKE_TIMEOUT) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAKE_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic [PTR_W-1:0]   winner_q, winner_idx;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               wake_err_q, err_set;
  logic [NUM_REQ-1:0] grant;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign accept = (state_q == ST_IDLE) && (|req_valid_i) && dev_opmode_i;

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) winner_idx = PTR_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wake_cnt_d = wake_cnt_q;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) state_d = dev_opmode_i ? ST_XFER : ST_WAKE;
      end
      ST_WAKE: begin
        if (dev_opmode_i) begin
          state_d    = ST_IDLE;
          wake_cnt_d = '0;
        end else if (wake_cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          wake_cnt_d = '0;
          err_set    = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (dev_ready_i) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (winner_q == PTR_LAST) ? '0 : winner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept pulse is combinational, so it is held off while reset is asserted.
  always_comb begin
    dev_valid_o = (state_q == ST_XFER);
    dev_wake_o  = (state_q == ST_WAKE);
    req_ready_o = (accept && !reset) ? grant : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      winner_q   <= '0;
      wake_err_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr_i[winner_idx];
        data_q   <= req_data_i[winner_idx];
        winner_q <= winner_idx;
      end
      if (err_set) wake_err_q <= 1'b1;
    end
  end

  assign dev_addr_o = addr_q;
  assign dev_data_o = data_q;
  assign wake_err_o = wake_err_q;

endmodule

// File: doc/dev_arbiter.md
DEV_ARBITER -- requirements
Module: dev_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports.
REQ-002 The block SHALL have parameter WAKE_TIMEOUT, default 16, meaning the maximum cycles spent waiting for device wake.
REQ-003 Port clk  input  1  is the clock; reset is asynchronous, active-high, named reset.
REQ-004 Port reset  input  1  is the asynchronous active-high reset.
REQ-005 Port req_valid_i  input  NUM_REQ  carries the per-requester request valid.
REQ-006 Port req_addr_i  input  NUM_REQ x 19  carries the per-requester device address.
REQ-007 Port req_data_i  input  NUM_REQ x 16  carries the per-requester write data.
REQ-008 Port req_ready_o  output  NUM_REQ  is a one-hot, single-cycle accept pulse.
REQ-009 Port dev_valid_o  output  1  is the device request valid.
REQ-010 Port dev_addr_o  output  19  is the device address.
REQ-011 Port dev_data_o  output  16  is the device data.
REQ-012 Port dev_ready_i  input  1  is the device ready.
REQ-013 Port dev_opmode_i  input  1  is the device status: 1 awake, 0 sleep.
REQ-014 Port dev_wake_o  output  1  is the wake request to the device.
REQ-015 Port wake_err_o  output  1  is a sticky flag indicating a wake timeout occurred.

Function
REQ-016 The FSM SHALL have states ST_IDLE, ST_WAKE and ST_XFER; any illegal encoding SHALL return to ST_IDLE.
REQ-017 In ST_IDLE with any req_valid_i set and dev_opmode_i=1, the block SHALL select a winner round-robin starting at pointer rr_ptr.
- In the same cycle it SHALL pulse req_ready_o[winner] and capture that requester's addr/data into the output registers.
- It SHALL then go to ST_XFER.
REQ-018 In ST_IDLE with any req_valid_i set and dev_opmode_i=0, the block SHALL enter ST_WAKE without accepting any request.
REQ-019 In ST_WAKE, dev_wake_o SHALL be 1 and a wake counter SHALL increment each cycle.
- On dev_opmode_i=1 the block SHALL return to ST_IDLE and clear the counter.
REQ-020 In ST_WAKE, if the counter reaches WAKE_TIMEOUT-1 with dev_opmode_i still 0:
- wake_err_o SHALL set and remain set until reset.
- The counter SHALL clear and the block SHALL return to ST_IDLE (retry permitted).
REQ-021 In ST_XFER, dev_valid_o SHALL be 1 and dev_addr_o/dev_data_o SHALL be held stable until dev_ready_i=1.
- On that handshake cycle the block SHALL go to ST_IDLE and set rr_ptr = (winner+1) mod NUM_REQ.
REQ-022 Latency: a request accepted in cycle c SHALL drive dev_valid_o in cycle c+1.
- After a handshake in cycle t, the next acceptance SHALL occur no earlier than t+1.
REQ-023 A dev_opmode_i drop during ST_XFER SHALL NOT abort the transfer.
REQ-024 req_ready_o SHALL be 0 outside the acceptance cycle, and never more than one bit SHALL be set at a time.
REQ-025 Requesters SHALL hold valid/addr/data until accepted; the block SHALL NOT store more than one request.
REQ-026 rr_ptr SHALL change only on a completed device handshake.

Reset
REQ-027 On reset the block SHALL set:
- state to ST_IDLE and rr_ptr to 0;
- the wake counter to 0;
- dev_valid_o, req_ready_o, dev_wake_o and wake_err_o to 0;
- dev_addr_o and dev_data_o to 0.
REQ-028 Reset asserted mid-transfer SHALL drop dev_valid_o immediately (asynchronously), without completing the transfer.

Structure
REQ-029 A shared package dev_arb_pkg SHALL hold state_t, ADDR_W=19 and DATA_W=16.
REQ-030 Winner selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant).
- rr_arbiter SHALL be purely combinational.

Verification
REQ-031 Single request, device awake and ready:
- Stimulus: opmode=1, req_valid_i=0001, addr=0x1_2345, data=0xBEEF.
- Response: req_ready_o=0001 in cycle c; dev_valid_o=1 with 0x12345/0xBEEF in c+1; IDLE in c+2.
REQ-032 All four requesters valid, dev_ready_i=1 constant:
- Response: grant order 0,1,2,3,0, with one acceptance every two cycles.
REQ-033 Device asleep:
- Stimulus: opmode=0, req_valid_i=0100; opmode rises after 5 cycles.
- Response: dev_wake_o=1 for those cycles, then requester 2 accepted, wake_err_o stays 0.
REQ-034 Wake timeout:
- Stimulus: opmode held 0 for 40 cycles.
- Response: wake_err_o=1 at cycle 16 of ST_WAKE, and it remains 1 thereafter.
REQ-035 Backpressure:
- Stimulus: dev_ready_i=0 for 10 cycles in ST_XFER, while addr inputs change and opmode drops.
- Response: dev_addr_o/dev_data_o stay stable and the transfer completes on dev_ready_i=1.
REQ-036 Reset during ST_XFER:
- Response: all outputs return to 0 and rr_ptr returns to 0; the first post-reset grant goes to requester 0.
